// File: rtl/ysyx_22040127_pkg.sv
// Shared IFU definitions: reset fetch address, IF->ID bus layout and the
// instruction-half selection helper.
package ysyx_22040127_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // IF->ID bus is {inst[31:0], pc[31:0]}
  localparam int unsigned IF_TO_ID_WIDTH = 64;
  localparam int unsigned BUS_PC_LSB     = 0;
  localparam int unsigned BUS_PC_MSB     = 31;
  localparam int unsigned BUS_INST_LSB   = 32;
  localparam int unsigned BUS_INST_MSB   = 63;

  // A fetch returns an aligned 8-byte line; pc[2] picks the 32-bit half.
  function automatic logic [31:0] pick_inst(input logic [63:0] line, input logic pc_bit2);
    return pc_bit2 ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22040127_fetch_queue.sv
// Fetch queue: in-order entry storage with head (pop), tail (allocate) and
// fill (oldest entry still waiting for its response) pointers.
module ysyx_22040127_fetch_queue
  import ysyx_22040127_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_flush,
  input  logic                           i_alloc,
  input  logic [31:0]                    i_alloc_pc,
  input  logic                           i_fill,
  input  logic [63:0]                    i_fill_data,
  input  logic                           i_pop,
  output logic [$clog2(DEPTH):0]         o_count,
  output logic                           o_head_ready,
  output logic [IF_TO_ID_WIDTH-1:0]      o_head_bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] r_alloc;
  logic [DEPTH-1:0] r_filled;
  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_inst [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW-1:0]    r_fill;
  logic [CW-1:0]    r_count;

  // Entry flags, pointers and occupancy; flush drops every entry at once.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_alloc  <= '0;
      r_filled <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_fill   <= '0;
      r_count  <= '0;
    end else begin
      if (i_alloc) begin
        r_alloc[r_tail]  <= 1'b1;
        r_filled[r_tail] <= 1'b0;
        r_tail           <= r_tail + 1'b1;
      end
      // Responses are in order, so the fill pointer always names the right entry.
      if (i_fill) begin
        r_filled[r_fill] <= 1'b1;
        r_fill           <= r_fill + 1'b1;
      end
      if (i_pop) begin
        r_alloc[r_head]  <= 1'b0;
        r_filled[r_head] <= 1'b0;
        r_head           <= r_head + 1'b1;
      end
      r_count <= r_count + CW'(i_alloc) - CW'(i_pop);
    end
  end

  // Payload storage needs no reset; the flags above qualify it.
  always_ff @(posedge clk) begin
    if (i_alloc && !rst && !i_flush) begin
      r_pc[r_tail] <= i_alloc_pc;
    end
    if (i_fill && !rst && !i_flush) begin
      r_inst[r_fill] <= pick_inst(i_fill_data, r_pc[r_fill][2]);
    end
  end

  // Head entry presented to the top; valid only once its data has arrived.
  always_comb begin
    o_count      = r_count;
    o_head_ready = r_alloc[r_head] & r_filled[r_head];
    o_head_bus   = '0;
    o_head_bus[BUS_PC_MSB:BUS_PC_LSB]     = r_pc[r_head];
    o_head_bus[BUS_INST_MSB:BUS_INST_LSB] = r_inst[r_head];
  end

endmodule

// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit: fetch pointer, in-flight accounting (total P and
// live L; P-L responses belong to a redirected-away stream) and request
// generation, feeding a fetch queue that presents instructions to ID.
module ysyx_22040127_ifu
  import ysyx_22040127_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [31:0]               req_addr,
  input  logic                      resp_valid,
  input  logic [63:0]               resp_data,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  input  logic                      id_allowin,
  output logic                      if_to_id_valid,
  output logic [IF_TO_ID_WIDTH-1:0] if_to_id_bus
);

  localparam int unsigned   CW      = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  logic [31:0]               r_fpc;
  logic [CW-1:0]             r_p;
  logic [CW-1:0]             r_l;
  logic [CW-1:0]             w_fq_count;
  logic                      w_head_ready;
  logic [IF_TO_ID_WIDTH-1:0] w_head_bus;
  logic                      w_fire;
  logic                      w_resp_any;
  logic                      w_resp_live;
  logic                      w_pop;
  logic                      w_unused_ok;

  assign w_unused_ok = ^redirect_pc[1:0];

  // Request, response classification and pop decisions for this cycle.
  always_comb begin
    req_valid      = !rst && !redirect_valid && (w_fq_count < DEPTH_C) && (r_p < DEPTH_C);
    req_addr       = {r_fpc[31:3], 3'b000};
    w_fire         = req_valid && req_ready;
    // Guard against a spurious response ever underflowing P.
    w_resp_any     = resp_valid && (r_p != '0);
    // Stale responses are always older than live ones, so P==L means live.
    w_resp_live    = w_resp_any && (r_p == r_l) && !redirect_valid && !rst;
    if_to_id_valid = !rst && !redirect_valid && w_head_ready;
    if_to_id_bus   = w_head_bus;
    w_pop          = if_to_id_valid && id_allowin;
  end

  // Fetch pointer and in-flight counters; a redirect orphans all live requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc <= RESET_PC;
      r_p   <= '0;
      r_l   <= '0;
    end else begin
      r_p <= r_p + CW'(w_fire) - CW'(w_resp_any);
      if (redirect_valid) begin
        r_fpc <= {redirect_pc[31:2], 2'b00};
        r_l   <= '0;
      end else begin
        if (w_fire) begin
          r_fpc <= r_fpc + 32'd4;
        end
        r_l <= r_l + CW'(w_fire) - CW'(w_resp_live);
      end
    end
  end

  ysyx_22040127_fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (redirect_valid),
    .i_alloc      (w_fire),
    .i_alloc_pc   (r_fpc),
    .i_fill       (w_resp_live),
    .i_fill_data  (resp_data),
    .i_pop        (w_pop),
    .o_count      (w_fq_count),
    .o_head_ready (w_head_ready),
    .o_head_bus   (w_head_bus)
  );

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// Directed and randomized bench for the IFU. A memory model answers requests
// in order after a programmable latency; a monitor records every pop.
module tb_ysyx_22040127_ifu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;

  ysyx_22040127_ifu #(
    .RESET_PC (32'h8000_0000),
    .FQ_DEPTH (4)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_allowin     (id_allowin),
    .if_to_id_valid (if_to_id_valid),
    .if_to_id_bus   (if_to_id_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned lat      = 1;
  int unsigned cyc      = 0;
  int unsigned req_cnt  = 0;
  int unsigned n_pops   = 0;
  logic [31:0] exp_pc;
  logic [63:0] bus;
  logic [31:0] req_log [$];
  logic [31:0] mq_addr [$];
  int unsigned mq_due  [$];
  logic [63:0] pop_q   [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory image: low word = addr ^ 1111_0000, high word = (addr+4) ^ 2222_0000.
  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'h2222_0000, a ^ 32'h1111_0000};
  endfunction

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc[2] ? (pc ^ 32'h2222_0000) : (pc ^ 32'h1111_0000);
  endfunction

  function automatic logic [63:0] pop_at(input int unsigned i);
    return (i < pop_q.size()) ? pop_q[i] : 64'hdead_beef_dead_beef;
  endfunction

  function automatic logic [31:0] log_at(input int unsigned i);
    return (i < req_log.size()) ? req_log[i] : 32'hdead_beef;
  endfunction

  // Memory: samples the request for the coming edge and drives that edge's response.
  initial begin
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
        resp_valid = 1'b0;
        resp_data  = '0;
      end else begin
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
          resp_valid = 1'b1;
          resp_data  = mem_data(mq_addr[0]);
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end else begin
          resp_valid = 1'b0;
          resp_data  = '0;
        end
        if (req_valid && req_ready) begin
          mq_addr.push_back(req_addr);
          mq_due.push_back(cyc + lat);
          req_log.push_back(req_addr);
          req_cnt++;
        end
      end
    end
  end

  // Monitor: records the bus whenever a pop will happen at the coming edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst && if_to_id_valid && id_allowin) pop_q.push_back(if_to_id_bus);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_ready      = 1'b0;
    id_allowin     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = 1;
    repeat (2) step();
    pop_q.delete();
    req_log.delete();
    req_cnt = 0;
  endtask

  task automatic wait_pops(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (pop_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, 64'(pop_q.size() >= n), 64'd1);
  endtask

  task automatic drain();
    while (pop_q.size() > 0) begin
      bus = pop_q.pop_front();
      check_eq("rnd_pc", {32'd0, bus[31:0]}, {32'd0, exp_pc});
      check_eq("rnd_inst", {32'd0, bus[63:32]}, {32'd0, inst_of(exp_pc)});
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end
  endtask

  initial begin
    rst            = 1'b1;
    req_ready      = 1'b0;
    id_allowin     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    do_reset();
    #1;
    check_eq("rst_req_valid", 64'(req_valid), 64'd0);
    check_eq("rst_out_valid", 64'(if_to_id_valid), 64'd0);
    check_eq("rst_req_addr", 64'(req_addr), 64'h8000_0000);

    // Streaming fetch, latency 1, ID always accepting
    rst = 1'b0; req_ready = 1'b1; id_allowin = 1'b1;
    #1;
    check_eq("t1_first_req_valid", 64'(req_valid), 64'd1);
    check_eq("t1_first_req_addr", 64'(req_addr), 64'h8000_0000);
    wait_pops(3, 20, "t1_pops");
    check_eq("t1_pop0", pop_at(0), {32'h9111_0000, 32'h8000_0000});
    check_eq("t1_pop1", pop_at(1), {32'hA222_0004, 32'h8000_0004});
    check_eq("t1_pop2", pop_at(2), {32'h9111_0008, 32'h8000_0008});
    check_eq("t1_addr1", 64'(log_at(1)), 64'h8000_0000);
    check_eq("t1_addr2", 64'(log_at(2)), 64'h8000_0008);

    // Back-pressure from ID fills the queue, then a single pop frees one slot
    do_reset();
    rst = 1'b0; req_ready = 1'b1; id_allowin = 1'b0;
    repeat (10) step();
    check_eq("t2_req_cnt", 64'(req_cnt), 64'd4);
    check_eq("t2_req_valid_low", 64'(req_valid), 64'd0);
    check_eq("t2_out_valid", 64'(if_to_id_valid), 64'd1);
    id_allowin = 1'b1;
    step();
    id_allowin = 1'b0;
    repeat (5) step();
    check_eq("t2_one_pop", 64'(pop_q.size()), 64'd1);
    check_eq("t2_pop_bus", pop_at(0), {32'h9111_0000, 32'h8000_0000});
    check_eq("t2_req_cnt_after", 64'(req_cnt), 64'd5);
    check_eq("t2_new_addr", 64'(log_at(4)), 64'h8000_0010);

    // Redirect with three requests in flight
    do_reset();
    rst = 1'b0; req_ready = 1'b1; id_allowin = 1'b0; lat = 10;
    repeat (3) step();
    req_ready = 1'b0;
    check_eq("t3_inflight", 64'(req_cnt), 64'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1002; id_allowin = 1'b1; req_ready = 1'b1;
    #1;
    check_eq("t3_redir_req_valid", 64'(req_valid), 64'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    check_eq("t3_redir_addr", 64'(req_addr), 64'h8000_1000);
    check_eq("t3_queue_empty", 64'(if_to_id_valid), 64'd0);
    wait_pops(1, 60, "t3_pops");
    check_eq("t3_first_pop", pop_at(0), {32'h9111_1000, 32'h8000_1000});
    check_eq("t3_req_after_redir", 64'(log_at(3)), 64'h8000_1000);

    // Redirect coincident with a response and a valid head
    do_reset();
    rst = 1'b0; req_ready = 1'b1; id_allowin = 1'b0; lat = 1;
    repeat (2) step();
    req_ready = 1'b0;
    check_eq("t4_head_valid", 64'(if_to_id_valid), 64'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000; id_allowin = 1'b1;
    #1;
    check_eq("t4_redir_out_valid", 64'(if_to_id_valid), 64'd0);
    step();
    redirect_valid = 1'b0; id_allowin = 1'b0; req_ready = 1'b1; lat = 20;
    repeat (8) step();
    check_eq("t4_no_pop", 64'(pop_q.size()), 64'd0);
    check_eq("t4_req_cnt", 64'(req_cnt), 64'd6);
    id_allowin = 1'b1;
    wait_pops(1, 60, "t4_pops");
    check_eq("t4_first_pop", pop_at(0), {32'h9111_2000, 32'h8000_2000});

    // Reset with two requests outstanding
    do_reset();
    rst = 1'b0; req_ready = 1'b1; id_allowin = 1'b0; lat = 5;
    repeat (2) step();
    check_eq("t5_outstanding", 64'(req_cnt), 64'd2);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_req_valid", 64'(req_valid), 64'd0);
    step();
    check_eq("t5_req_valid", 64'(req_valid), 64'd0);
    check_eq("t5_out_valid", 64'(if_to_id_valid), 64'd0);
    check_eq("t5_fpc", 64'(req_addr), 64'h8000_0000);
    pop_q.delete();
    rst = 1'b0; lat = 1; id_allowin = 1'b1;
    wait_pops(2, 20, "t5_pops");
    check_eq("t5_pop0", pop_at(0), {32'h9111_0000, 32'h8000_0000});
    check_eq("t5_pop1", pop_at(1), {32'hA222_0004, 32'h8000_0004});

    // Random ready/allowin/latency with occasional redirects
    do_reset();
    rst    = 1'b0;
    exp_pc = 32'h8000_0000;
    n_pops = 0;
    for (int i = 0; i < 800; i++) begin
      req_ready      = ($urandom_range(0, 3) != 0);
      id_allowin     = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 5);
      redirect_valid = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000 | ($urandom & 32'h0000_fffe);
        exp_pc         = redirect_pc & 32'hffff_fffc;
      end
      step();
      drain();
    end
    redirect_valid = 1'b0;
    check_eq("rnd_progress", 64'(n_pops > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
